// File: rtl/sigma_delta_pkg.sv
// Shared sigma-delta helpers: frame-counter and CIC sizing used by both the ADC and the DAC,
// plus the per-strobe action encoding of the DAC sample path.
package sigma_delta_pkg;

    function automatic int frame_cnt_width(input int osr);
        return (osr > 1) ? $clog2(osr) : 1;
    endfunction

    // One extra bit carries the sign of the comb differences.
    function automatic int cic_width(input int bitlen, input int stages, input int osr);
        return bitlen + stages * $clog2(osr) + 1;
    endfunction

    function automatic int cic_shift(input int stages, input int osr);
        return (stages - 1) * $clog2(osr);
    endfunction

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_STORE,
        ACT_RELOAD,
        ACT_DIRECT,
        ACT_UNDERRUN
    } frame_action_e;

endpackage

// File: rtl/cic_comb.sv
// CIC comb stage: difference against the previous enabled sample, delay advanced on en_i only.
module cic_comb #(
    parameter int WIDTH = 33
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic signed [WIDTH-1:0] data_i,
    output logic signed [WIDTH-1:0] data_o
);

    logic signed [WIDTH-1:0] dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q <= '0;
        end else if (en_i) begin
            dly_q <= data_i;
        end
    end

    assign data_o = data_i - dly_q;

endmodule

// File: rtl/cic_integrator.sv
// CIC integrator stage: registered running sum, wraps modulo 2^WIDTH by design.
module cic_integrator #(
    parameter int WIDTH = 33
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] data_i,
    output logic signed [WIDTH-1:0] data_o
);

    logic signed [WIDTH-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_q + data_i;
        end
    end

    assign data_o = acc_q;

endmodule

// File: rtl/sigma_delta_mod1.sv
// First-order 1-bit modulator: the accumulator carry is the output bit.
module sigma_delta_mod1 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    output logic             pin
);

    logic [WIDTH:0] acc_q;
    logic [WIDTH:0] sum;

    // The carry is dropped before each add, so the sum can never exceed WIDTH+1 bits.
    assign sum = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, x};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= sum;
        end
    end

    assign pin = acc_q[WIDTH];

endmodule

// File: rtl/sigma_delta_dac.sv
// Sigma-delta DAC: one-entry sample buffer, frame-rate reload, first-order modulator.
// Optional CIC interpolation between active sample and modulator: SIGMA_DELTA_DAC_INTERP_EN.
module sigma_delta_dac
    import sigma_delta_pkg::*;
#(
    parameter int OVERSAMPLE_RATE = 256,
    parameter int DAC_BITLEN      = 16,
    parameter int CIC_STAGES      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DAC_BITLEN-1:0] dac_input,
    input  logic                  dac_valid,
    output logic                  dac_ready,
    output logic                  dac_pin,
    output logic                  dac_underrun
);

    localparam int FW = frame_cnt_width(OVERSAMPLE_RATE);
    localparam logic [FW-1:0] LAST_POS = FW'(OVERSAMPLE_RATE - 1);

    if (OVERSAMPLE_RATE < 4 || (OVERSAMPLE_RATE & (OVERSAMPLE_RATE - 1)) != 0 || CIC_STAGES < 1)
    begin : g_bad_cfg
        $error("sigma_delta_dac: OVERSAMPLE_RATE must be a power of two >= 4, CIC_STAGES >= 1");
    end

    logic [FW-1:0]         cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic [DAC_BITLEN-1:0] buf_q, buf_d;
    logic [DAC_BITLEN-1:0] active_q, active_d;
    logic                  underrun_q, underrun_d;
    logic                  strobe;
    logic                  accept;
    logic [DAC_BITLEN-1:0] mod_x;
    frame_action_e         action;

    assign strobe    = (cnt_q == LAST_POS);
    assign dac_ready = !full_q && !rst;
    assign accept    = dac_valid && dac_ready;

    // NOTE: every signal driven here gets its default first, so no path can infer a latch.
    always_comb begin
        action     = ACT_NONE;
        cnt_d      = cnt_q + FW'(1);
        full_d     = full_q;
        buf_d      = buf_q;
        active_d   = active_q;
        underrun_d = 1'b0;

        if (strobe) begin
            if (full_q) begin
                action = ACT_RELOAD;
            end else if (accept) begin
                action = ACT_DIRECT;
            end else begin
                action = ACT_UNDERRUN;
            end
        end else if (accept) begin
            action = ACT_STORE;
        end

        case (action)
            ACT_STORE: begin
                buf_d  = dac_input;
                full_d = 1'b1;
            end
            ACT_RELOAD: begin
                active_d = buf_q;
                full_d   = 1'b0;
            end
            ACT_DIRECT:   active_d   = dac_input;
            ACT_UNDERRUN: underrun_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            full_q     <= 1'b0;
            active_q   <= '0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            active_q   <= active_d;
            underrun_q <= underrun_d;
        end
    end

    // NOTE: the buffer data needs no reset; it is only read while full_q marks it valid.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign dac_underrun = underrun_q;

`ifdef SIGMA_DELTA_DAC_INTERP_EN
    localparam int CW        = cic_width(DAC_BITLEN, CIC_STAGES, OVERSAMPLE_RATE);
    localparam int CIC_SHIFT = cic_shift(CIC_STAGES, OVERSAMPLE_RATE);
    localparam logic signed [CW-1:0] X_MAX =
        $signed({{(CW - DAC_BITLEN){1'b0}}, {DAC_BITLEN{1'b1}}});

    logic                 load_q;
    logic signed [CW-1:0] comb_s  [CIC_STAGES+1];
    logic signed [CW-1:0] integ_s [CIC_STAGES+1];
    logic signed [CW-1:0] scaled;

    // Combs run in the cycle after the strobe, when active_q already holds the new sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_q <= 1'b0;
        end else begin
            load_q <= strobe;
        end
    end

    assign comb_s[0] = $signed({{(CW - DAC_BITLEN){1'b0}}, active_q});

    for (genvar g = 0; g < CIC_STAGES; g++) begin : g_comb
        cic_comb #(.WIDTH(CW)) u_comb (
            .clk    (clk),
            .rst    (rst),
            .en_i   (load_q),
            .data_i (comb_s[g]),
            .data_o (comb_s[g+1])
        );
    end

    assign integ_s[0] = load_q ? comb_s[CIC_STAGES] : '0;

    for (genvar g = 0; g < CIC_STAGES; g++) begin : g_integ
        cic_integrator #(.WIDTH(CW)) u_integ (
            .clk    (clk),
            .rst    (rst),
            .data_i (integ_s[g]),
            .data_o (integ_s[g+1])
        );
    end

    assign scaled = integ_s[CIC_STAGES] >>> CIC_SHIFT;

    // Overshoot on steps is clipped to the modulator's unsigned range.
    always_comb begin
        if (scaled < 0) begin
            mod_x = '0;
        end else if (scaled > X_MAX) begin
            mod_x = '1;
        end else begin
            mod_x = scaled[DAC_BITLEN-1:0];
        end
    end
`else
    assign mod_x = active_q;
`endif

    sigma_delta_mod1 #(.WIDTH(DAC_BITLEN)) u_mod (
        .clk (clk),
        .rst (rst),
        .x   (mod_x),
        .pin (dac_pin)
    );

endmodule

// File: doc/sigma_delta_dac.md
SIGMA_DELTA_DAC -- requirements
Module: sigma_delta_dac

Interface
REQ-001 SHALL have parameter OVERSAMPLE_RATE, default 256: modulator clocks per input sample; power of two, at least 4.
REQ-002 SHALL have parameter DAC_BITLEN, default 16: input sample width, unsigned offset binary.
REQ-003 SHALL have parameter CIC_STAGES, default 2: interpolator order; used only when SIGMA_DELTA_DAC_INTERP_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port dac_input, input, DAC_BITLEN bits: sample to convert.
REQ-007 SHALL have port dac_valid, input, 1 bit: dac_input is valid this cycle.
REQ-008 SHALL have port dac_ready, output, 1 bit: the one-entry holding buffer is empty.
REQ-009 SHALL have port dac_pin, output, 1 bit: registered 1-bit stream to the external RC filter.
REQ-010 SHALL have port dac_underrun, output, 1 bit: one-cycle pulse when a frame starts with no new sample.

Function
REQ-011 SHALL run frame counter 0..OVERSAMPLE_RATE-1, wrapping; a strobe is the cycle where the count equals OVERSAMPLE_RATE-1.
REQ-012 SHALL accept a sample when dac_valid and dac_ready are both high, latching it into the holding buffer and setting it full.
REQ-013 SHALL drive dac_ready = !full; no accept while full, and dac_input is ignored.
REQ-014 SHALL, at a strobe with the buffer full, copy the buffer to the active sample and clear full.
REQ-015 SHALL, at a strobe with the buffer empty and an accept in the same cycle, load the accepted sample directly into the active sample, leave the buffer empty, and not flag underrun.
REQ-016 SHALL, at a strobe with the buffer empty and no accept, keep the active sample and pulse dac_underrun high for the next cycle only.
REQ-017 SHALL run a first-order modulator with a DAC_BITLEN+1 bit accumulator: sum = {0, acc[DAC_BITLEN-1:0]} + x; acc <= sum; dac_pin <= sum[DAC_BITLEN].
REQ-018 SHALL make the long-run density of ones on dac_pin equal x / 2^DAC_BITLEN, where x is the modulator input.
REQ-019 SHALL present a newly active sample to the modulator on the cycle after the strobe, with dac_pin reflecting it one cycle later; total latency is 2 cycles after the strobe.
REQ-020 SHALL compute the modulator input x with no intermediate overflow at any input value, including 0 and 2^DAC_BITLEN-1.

Reset
REQ-021 SHALL, while rst is high, hold dac_pin=0, dac_ready=0, dac_underrun=0, frame count=0, accumulator=0, active sample=0, buffer empty, and all interpolator state=0.
REQ-022 SHALL raise dac_ready on the first cycle after rst falls.
REQ-023 SHALL, on rst mid-frame, discard any buffered sample; the next strobe occurs OVERSAMPLE_RATE cycles after rst falls.

Configuration
REQ-024 SHALL, with macro SIGMA_DELTA_DAC_INTERP_EN undefined, feed the active sample straight to the modulator as a zero-order hold.
REQ-025 SHALL, with SIGMA_DELTA_DAC_INTERP_EN defined, insert a CIC interpolator between the active sample and the modulator.
REQ-026 The interpolator SHALL clock its CIC_STAGES comb stages on strobes only.
REQ-027 The interpolator SHALL zero-stuff between strobes and run CIC_STAGES integrators every cycle.
REQ-028 The interpolator SHALL use width DAC_BITLEN + CIC_STAGES*log2(OVERSAMPLE_RATE) + 1 (sign).
REQ-029 The interpolator SHALL right-shift by (CIC_STAGES-1)*log2(OVERSAMPLE_RATE) and clip to 0..2^DAC_BITLEN-1; negative results clip to 0.
REQ-030 The interpolator SHALL reach steady state for a constant input within CIC_STAGES frames, with x equal to that input.

Structure
REQ-031 SHALL place the CIC width, shift, and frame-count width derivation functions in a shared package used by both the ADC and the DAC.
REQ-032 SHALL implement the modulator as the single sub-module sigma_delta_mod1 (ports: clk, rst, x, pin).
REQ-033 SHALL reuse the existing cic_integrator and cic_comb blocks for the interpolator.

Verification
REQ-034 Bench SHALL drive constant input 0 for 4 frames: dac_pin stays 0 and dac_underrun pulses once per frame after the first.
REQ-035 Bench SHALL drive 0x8000 each frame (DAC_BITLEN=16, OSR=256): exactly 128 ones per 256-cycle window once the active sample has loaded, and dac_pin alternates 0/1.
REQ-036 Bench SHALL drive 0xFFFF: 255 or 256 ones per window; no overflow wrap to a zero run.
REQ-037 Bench SHALL hold dac_valid high continuously: exactly one accept per frame, dac_ready low from accept to the next strobe, and no underrun.
REQ-038 Bench SHALL assert rst for 3 cycles mid-frame with the buffer full: all outputs 0 during rst, dac_ready=1 the cycle after, buffered sample lost, next strobe 256 cycles later.
REQ-039 Bench SHALL step the input 0→0x4000 with interpolation enabled: the ones count per window rises monotonically to 64 within CIC_STAGES+1 frames.
